// File: rtl/if_stage_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and imem.
// The master side drives the request and address; the slave answers.
interface if_stage_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage_fetch_unit.sv
// Instruction fetch stage with variable-latency imem handshake and the
// IF/ID pipeline register; honours hazard freeze and EXE branch redirect.
module if_stage_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [ADDR_W-1:0]     branch_addr,
    if_stage_fetch_unit_if.master imem,
    output logic                  if_id_valid,
    output logic [ADDR_W-1:0]     if_id_pc,
    output logic [INSTR_W-1:0]    if_id_instr
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        FULL
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_q;
    logic               drop_q, drop_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic [INSTR_W-1:0] buf_q, buf_d;
    logic               v_q, v_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic [INSTR_W-1:0] ins_q, ins_d;

    logic               ack_ok;
    logic               deliver;
    logic [INSTR_W-1:0] load_data;
    logic [ADDR_W-1:0]  pc_inc;

    assign ack_ok = req_q & imem.imem_ack;
    assign pc_inc = pc_q + ADDR_W'(PC_STEP);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        target_d  = target_q;
        buf_d     = buf_q;
        deliver   = 1'b0;
        load_data = imem.imem_rdata;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (ack_ok) begin
                    if (branch_taken) begin
                        pc_d   = branch_addr;
                        drop_d = 1'b0;
                    end else if (drop_q) begin
                        pc_d   = target_q;
                        drop_d = 1'b0;
                    end else if (!freeze) begin
                        deliver = 1'b1;
                        pc_d    = pc_inc;
                    end else begin
                        buf_d   = imem.imem_rdata;
                        state_d = FULL;
                    end
                end else if (branch_taken) begin
                    // address must stay put until the ack; remember the redirect
                    drop_d   = 1'b1;
                    target_d = branch_addr;
                end
            end
            FULL: begin
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    state_d = FETCH;
                end else if (!freeze) begin
                    deliver   = 1'b1;
                    load_data = buf_q;
                    pc_d      = pc_inc;
                    state_d   = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        v_d   = v_q;
        ipc_d = ipc_q;
        ins_d = ins_q;
        if (branch_taken) begin
            v_d   = 1'b0;
            ipc_d = '0;
            ins_d = '0;
        end else if (freeze) begin
            v_d = v_q;
        end else if (deliver) begin
            v_d   = 1'b1;
            ipc_d = pc_inc;
            ins_d = load_data;
        end else begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            drop_q   <= 1'b0;
            target_q <= '0;
            buf_q    <= '0;
            v_q      <= 1'b0;
            ipc_q    <= '0;
            ins_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= (state_d == FETCH);
            drop_q   <= drop_d;
            target_q <= target_d;
            buf_q    <= buf_d;
            v_q      <= v_d;
            ipc_q    <= ipc_d;
            ins_q    <= ins_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_id_valid    = v_q;
    assign if_id_pc       = ipc_q;
    assign if_id_instr    = ins_q;

endmodule

// File: tb/tb_if_stage_fetch_unit.sv
// Directed bench for the fetch stage: stimulus pushes expected IF/ID
// deliveries into a queue, a negedge monitor pops and compares them.
module tb_if_stage_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          cnt = 0;
    logic        ack_force = 1'b0;
    logic        held = 1'b0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_item;

    if_stage_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

    if_stage_fetch_unit #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem.master),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_instr  (if_id_instr)
    );

    always #5 clk = ~clk;

    // memory: ack after lat wait cycles, rdata tagged with the address
    assign imem.imem_ack   = ack_force | (imem.imem_req && cnt == lat);
    assign imem.imem_rdata = 32'hE000_0000 | imem.imem_addr;

    always @(posedge clk) begin
        if (!imem.imem_req || imem.imem_ack) cnt <= 0;
        else cnt <= cnt + 1;
        held <= freeze;
    end

    function automatic logic [31:0] ins(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && if_id_valid && !held) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected none",
                         if_id_pc, if_id_instr);
            end else begin
                exp_item = exp_q.pop_front();
                if ({if_id_pc, if_id_instr} !== exp_item) begin
                    errors++;
                    $display("FAIL sb_ifid: got %h_%h expected %h_%h",
                             if_id_pc, if_id_instr,
                             exp_item[63:32], exp_item[31:0]);
                end
            end
        end
    end

    initial begin
        step();
        step();
        chk("rst_req", 32'(imem.imem_req), 32'd0);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_addr", imem.imem_addr, 32'h0);
        chk("rst_ifpc", if_id_pc, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        rst = 1'b0;
        exp_q.push_back({32'h4, ins(32'h0)});
        exp_q.push_back({32'h8, ins(32'h4)});
        exp_q.push_back({32'hC, ins(32'h8)});
        exp_q.push_back({32'h10, ins(32'hC)});
        exp_q.push_back({32'h44, ins(32'h40)});

        step();
        chk("boot_addr", imem.imem_addr, 32'h0);
        chk("boot_req", 32'(imem.imem_req), 32'd1);
        chk("boot_valid", 32'(if_id_valid), 32'd0);
        step();
        chk("t1_addr4", imem.imem_addr, 32'h4);
        chk("t1_valid", 32'(if_id_valid), 32'd1);
        step();
        chk("t1_addr8", imem.imem_addr, 32'h8);
        freeze = 1'b1;

        step();
        chk("t2_req", 32'(imem.imem_req), 32'd0);
        chk("t2_hold_pc", if_id_pc, 32'h8);
        chk("t2_hold_instr", if_id_instr, ins(32'h4));
        step();
        step();
        chk("t2_still_req", 32'(imem.imem_req), 32'd0);
        chk("t2_hold_valid", 32'(if_id_valid), 32'd1);
        freeze = 1'b0;
        step();
        chk("t2_rel_pc", if_id_pc, 32'hC);
        chk("t2_rel_instr", if_id_instr, ins(32'h8));
        chk("t2_addr", imem.imem_addr, 32'hC);
        chk("t2_req1", 32'(imem.imem_req), 32'd1);

        step();
        chk("t3_addr", imem.imem_addr, 32'h10);
        branch_taken = 1'b1;
        branch_addr  = 32'h40;
        step();
        branch_taken = 1'b0;
        chk("t3_valid", 32'(if_id_valid), 32'd0);
        chk("t3_instr", if_id_instr, 32'h0);
        chk("t3_addr40", imem.imem_addr, 32'h40);
        step();
        chk("t3_pc", if_id_pc, 32'h44);
        chk("t3_ins", if_id_instr, ins(32'h40));
        branch_taken = 1'b1;
        branch_addr  = 32'h20;

        step();
        branch_taken = 1'b0;
        lat = 3;
        chk("t4_addr", imem.imem_addr, 32'h20);
        exp_q.push_back({32'h84, ins(32'h80)});
        step();
        chk("t4_wait_addr", imem.imem_addr, 32'h20);
        branch_taken = 1'b1;
        branch_addr  = 32'h80;
        step();
        branch_taken = 1'b0;
        chk("t4_addr_hold", imem.imem_addr, 32'h20);
        chk("t4_bubble", 32'(if_id_valid), 32'd0);
        step();
        chk("t4_addr_hold2", imem.imem_addr, 32'h20);
        step();
        chk("t4_redirect", imem.imem_addr, 32'h80);
        chk("t4_no_load", 32'(if_id_valid), 32'd0);
        lat = 0;
        step();
        chk("t4_valid", 32'(if_id_valid), 32'd1);

        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        exp_q.push_back({32'h104, ins(32'h100)});
        step();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        chk("t5_flush", 32'(if_id_valid), 32'd0);
        chk("t5_addr", imem.imem_addr, 32'h100);
        step();
        chk("t5_valid2", 32'(if_id_valid), 32'd1);
        branch_taken = 1'b1;
        branch_addr  = 32'h30;

        step();
        branch_taken = 1'b0;
        lat = 3;
        chk("t6_addr", imem.imem_addr, 32'h30);
        chk("t6_req", 32'(imem.imem_req), 32'd1);
        #3;
        rst = 1'b1;
        ack_force = 1'b1;
        #1;
        chk("t6_rst_req", 32'(imem.imem_req), 32'd0);
        chk("t6_rst_valid", 32'(if_id_valid), 32'd0);
        chk("t6_rst_pc", if_id_pc, 32'h0);
        chk("t6_rst_instr", if_id_instr, 32'h0);
        chk("t6_rst_addr", imem.imem_addr, 32'h0);
        step();
        chk("t6_rst_hold", 32'(imem.imem_req), 32'd0);
        rst = 1'b0;
        step();
        ack_force = 1'b0;
        lat = 0;
        chk("t6_boot_valid", 32'(if_id_valid), 32'd0);
        chk("t6_boot_addr", imem.imem_addr, 32'h0);
        chk("t6_boot_req", 32'(imem.imem_req), 32'd1);
        exp_q.push_back({32'h4, ins(32'h0)});
        exp_q.push_back({32'h8, ins(32'h4)});
        exp_q.push_back({32'hC, ins(32'h8)});
        step();
        chk("t6_valid", 32'(if_id_valid), 32'd1);
        chk("t6_pc", if_id_pc, 32'h4);
        step();
        step();
        @(negedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage_fetch_unit.md
Name: if_stage_fetch_unit

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage core. It sits directly upstream of the hazard detection unit. It issues requests to instruction memory with a variable-latency req/ack handshake and captures results into the IF/ID register. The hazard output drives `freeze`, and an EXE-stage taken branch drives the flush and redirect.

Parameters:
ADDR_W, 32, PC / address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
freeze  input  1  stall from hazard unit; holds PC and IF/ID
branch_taken  input  1  taken branch from EXE; flush and redirect
branch_addr  input  ADDR_W  branch target, valid when branch_taken=1
imem_req  output  1  fetch request (registered)
imem_addr  output  ADDR_W  fetch address; equals PC
imem_ack  input  1  memory returns data this cycle; may be high in the same cycle imem_req rises
imem_rdata  input  INSTR_W  instruction, valid when imem_ack=1
if_id_valid  output  1  IF/ID holds a real instruction
if_id_pc  output  ADDR_W  fetched address + PC_STEP
if_id_instr  output  INSTR_W  fetched instruction

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=BOOT, imem_req=0, drop=0.
  - if_id_valid=0, if_id_pc=0, if_id_instr=0, buffer=0.
- imem_addr=pc at all times. pc never changes while imem_req=1 and no ack has arrived (address stable during a request).
- Acknowledged fetch: an ack counts only when imem_req=1 and imem_ack=1 in the same cycle. imem_ack while imem_req=0 is ignored.
- States:
  - BOOT: imem_req=0; next cycle go to FETCH with imem_req=1.
  - FETCH: imem_req=1. On an ack, evaluate in this priority order:
    (a) branch_taken=1 this cycle: discard rdata, pc<=branch_addr, drop<=0, stay in FETCH.
    (b) drop=1: discard rdata, pc<=target, drop<=0, stay in FETCH.
    (c) freeze=0: IF/ID<={1, pc+PC_STEP, rdata}, pc<=pc+PC_STEP, stay in FETCH.
    (d) freeze=1: buffer<=rdata, go to FULL, imem_req<=0.
  - FETCH, no ack, branch_taken=1: drop<=1, target<=branch_addr. A later branch before the ack overwrites target (last branch wins).
  - FULL: imem_req=0.
    - branch_taken=1: discard buffer, pc<=branch_addr, go to FETCH.
    - else freeze=0: IF/ID<={1, pc+PC_STEP, buffer}, pc<=pc+PC_STEP, go to FETCH.
    - else: hold.
- IF/ID update rules, in priority order:
  1. branch_taken=1: valid<=0, instr<=0, pc<=0 (flush overrides freeze).
  2. freeze=1: hold all fields.
  3. Delivery this cycle per (c) or FULL release: load.
  4. Otherwise: valid<=0 (bubble).
- Throughput and latency:
  - With a zero-wait memory (ack same cycle as req): one instruction per cycle.
  - First valid IF/ID appears 2 cycles after reset release.
  - Fetch-to-IF/ID latency: 1 cycle after the ack edge.
- PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Reset during an outstanding request: the request is abandoned and a late ack is ignored (imem_req=0 in BOOT).

Test Plan:
1. Reset release, zero-wait memory, rdata=0xE000_0000|addr:
   - imem_addr sequence 0,4,8,12 on consecutive cycles.
   - if_id_pc 4,8,12 with valid=1 from the 2nd cycle after release.
2. Zero-wait memory, freeze=1 for 3 cycles starting when addr=8:
   - State goes to FULL and imem_req=0; IF/ID holds pc=8 and instr of addr 4.
   - After freeze drops: next cycle IF/ID={1,12,instr(8)}, imem_addr=12, imem_req=1.
3. branch_taken=1, branch_addr=0x40, coincident with ack at addr=0x10:
   - Next cycle if_id_valid=0, if_id_instr=0, imem_addr=0x40.
   - The following cycle IF/ID={1,0x44,instr(0x40)}.
4. 3-cycle memory latency, branch to 0x80 in the 2nd wait cycle at addr=0x20:
   - imem_addr stays 0x20 until ack; returned data is not loaded.
   - Next request is at 0x80; IF/ID shows only bubbles in between.
5. freeze=1 and branch_taken=1 (branch_addr=0x100) in the same cycle, with valid IF/ID:
   - IF/ID flushed (valid=0); next fetch address 0x100.
6. rst asserted mid-cycle while imem_req=1 at addr=0x30:
   - imem_req, if_id_* all 0 immediately, pc=0.
   - An ack during reset is ignored; fetch restarts at 0 after BOOT.
